wb_ram_arbiter: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter that shares the on-chip byte-lane RAM between the CPU data/instruction port (m0) and a second requester such as a UART boot loader or DMA (m1).
- Sits between naive_soc-side masters and wb_ram.
- Grant is held for a whole bus cycle, i.e. while the owner's cyc is high.
- A watchdog terminates stalled slave accesses with an error pulse.

---
 rtl/wb_ram_arbiter_if.sv | 14 +
 rtl/wb_ram_arbiter.sv | 66 ++++++
 tb/tb_wb_ram_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_arbiter_if.sv
// wb_ram_arbiter_if: one Wishbone classic link; master drives the request, slave answers it
interface wb_ram_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  modport master (output addr, wdata, sel, we, cyc, stb, input rdata, ack);
  modport slave  (input addr, wdata, sel, we, cyc, stb, output rdata, ack, err);
endinterface

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone arbiter for the shared RAM with a stalled-access watchdog.
// Define WB_RAM_ARB_RR_EN for round-robin tie breaking; otherwise m0 always wins ties.
module wb_ram_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  wb_ram_arbiter_if.slave  m0,
  wb_ram_arbiter_if.slave  m1,
  wb_ram_arbiter_if.master s,
  output logic [1:0]       grant
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_own0, w_own1, w_cyc, w_stb, w_pend, w_tmo, w_m1_wins;
  assign w_own0 = r_state == OWN0;
  assign w_own1 = r_state == OWN1;
  assign grant  = {w_own1, w_own0};
  assign w_cyc  = w_own0 ? m0.cyc : w_own1 ? m1.cyc : 1'b0;
  assign w_stb  = w_own0 ? m0.stb : w_own1 ? m1.stb : 1'b0;
  assign s.cyc   = w_cyc;
  assign s.stb   = w_stb & ~r_err;
  assign s.we    = w_own0 ? m0.we    : w_own1 ? m1.we    : 1'b0;
  assign s.sel   = w_own0 ? m0.sel   : w_own1 ? m1.sel   : 4'h0;
  assign s.addr  = w_own0 ? m0.addr  : w_own1 ? m1.addr  : 32'h0;
  assign s.wdata = w_own0 ? m0.wdata : w_own1 ? m1.wdata : 32'h0;
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  assign m0.ack   = w_own0 & s.ack;
  assign m1.ack   = w_own1 & s.ack;
  assign m0.err   = w_own0 & r_err;
  assign m1.err   = w_own1 & r_err;
`ifdef WB_RAM_ARB_RR_EN
  logic r_last;
  assign w_m1_wins = ~r_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= 1'b1;
    else if (w_next != r_state && w_next != IDLE) r_last <= w_next == OWN1;
`else
  assign w_m1_wins = 1'b0;
`endif
  // Owner keeps the bus while its cyc is high; on release the waiting master takes over directly.
  always_comb begin
    w_next = w_own0 ? (m0.cyc ? OWN0 : m1.cyc ? OWN1 : IDLE)
           : w_own1 ? (m1.cyc ? OWN1 : m0.cyc ? OWN0 : IDLE)
           : (m0.cyc & m1.cyc) ? (w_m1_wins ? OWN1 : OWN0)
           : m0.cyc ? OWN0 : m1.cyc ? OWN1 : IDLE;
  end
  // The err cycle itself does not count, so a still-held strobe restarts a fresh timeout window.
  assign w_pend = w_cyc & w_stb & ~s.ack & ~r_err;
  assign w_tmo  = (TIMEOUT_CYCLES != 0) && w_pend && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_tmo;
      r_cnt   <= (w_next != r_state || !w_pend || w_tmo) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: directed scenarios plus random traffic checked against an ownership model
module tb_wb_ram_arbiter;
  localparam int T = 4;
`ifdef WB_RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [1:0] grant;
  always #5 clk = ~clk;
  wb_ram_arbiter_if m0 ();
  wb_ram_arbiter_if m1 ();
  wb_ram_arbiter_if s ();
  wb_ram_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .m0(m0), .m1(m1), .s(s), .grant(grant));
  int n_chk = 0;
  int n_err = 0;
  int own, pend, win, exp_own;
  bit mlast, merr, pc0, ps0, pc1, ps1, pa;
  logic [1:0] eg;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_m(input int m, input logic c, input logic st, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0.cyc = c; m0.stb = st; m0.we = w; m0.addr = a; m0.wdata = d; m0.sel = 4'hF;
    end else begin
      m1.cyc = c; m1.stb = st; m1.we = w; m1.addr = a; m1.wdata = d; m1.sel = 4'hF;
    end
  endtask
  task automatic chk_outs(input string tag, input logic [1:0] g, input logic sc, input logic ss,
                          input logic a0, input logic a1, input logic e0, input logic e1);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".s_cyc"}, s.cyc, sc);
    chk({tag, ".s_stb"}, s.stb, ss);
    chk({tag, ".m0_ack"}, m0.ack, a0);
    chk({tag, ".m1_ack"}, m1.ack, a1);
    chk({tag, ".m0_err"}, m0.err, e0);
    chk({tag, ".m1_err"}, m1.err, e1);
  endtask
  function automatic logic [1:0] onehot(input int m);
    return m == 1 ? 2'b01 : m == 2 ? 2'b10 : 2'b00;
  endfunction
  // Model: who owns the bus, and how many consecutive cycles the owner's strobe has gone unanswered.
  function automatic void advance();
    bit ocyc, ostb, nerr;
    int nown;
    ocyc = own == 1 ? pc0 : own == 2 ? pc1 : 1'b0;
    ostb = own == 1 ? ps0 : own == 2 ? ps1 : 1'b0;
    nerr = 1'b0;
    if (own == 0) nown = (pc0 && pc1) ? ((RR && !mlast) ? 2 : 1) : pc0 ? 1 : pc1 ? 2 : 0;
    else nown = ocyc ? own : ((own == 1 ? pc1 : pc0) ? 3 - own : 0);
    if (ocyc && ostb && !pa && !merr && nown == own) begin
      pend++;
      if (pend == T) begin nerr = 1'b1; pend = 0; end
    end else pend = 0;
    if (nown != own) pend = 0;
    if (nown != 0 && nown != own) mlast = nown == 2;
    own = nown;
    merr = nerr;
  endfunction
  initial begin
    reset = 1'b1;
    set_m(0, 1, 1, 1, 32'h55, 32'h1234);
    set_m(1, 0, 0, 0, 0, 0);
    s.ack = 1'b0; s.err = 1'b0; s.rdata = 32'h0;
    #12;
    chk_outs("reset", 2'b00, 0, 0, 0, 0, 0, 0);
    chk("reset.s_we", s.we, 0);
    chk("reset.s_sel", s.sel, 0);
    chk("reset.s_addr", s.addr, 0);
    chk("reset.s_wdata", s.wdata, 0);
    set_m(0, 0, 0, 0, 0, 0);
    #10 reset = 1'b0;
    // single master read, ack two cycles after strobe
    tick;
    set_m(0, 1, 1, 0, 32'h10, 0);
    #2 chk("rd.latency", grant, 2'b00);
    tick; #2;
    chk_outs("rd.strobe", 2'b01, 1, 1, 0, 0, 0, 0);
    chk("rd.s_addr", s.addr, 32'h10);
    chk("rd.s_we", s.we, 0);
    chk("rd.s_sel", s.sel, 4'hF);
    tick; #2;
    chk_outs("rd.wait", 2'b01, 1, 1, 0, 0, 0, 0);
    tick;
    s.ack = 1'b1; s.rdata = 32'hDEADBEEF;
    #2;
    chk_outs("rd.ack", 2'b01, 1, 1, 1, 0, 0, 0);
    chk("rd.m0_rdata", m0.rdata, 32'hDEADBEEF);
    chk("rd.m1_rdata", m1.rdata, 32'hDEADBEEF);
    tick;
    s.ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    #2 chk_outs("rd.release", 2'b01, 0, 0, 0, 0, 0, 0);
    tick; #2 chk("rd.idle", grant, 2'b00);
    // simultaneous request, then handoff without an idle bubble
    win = RR ? 1 : 0;
    set_m(0, 1, 1, 0, 32'h100, 0);
    set_m(1, 1, 1, 0, 32'h200, 0);
    #2 chk("tie.latency", grant, 2'b00);
    tick; #2;
    chk("tie.winner", grant, onehot(win + 1));
    chk("tie.s_addr", s.addr, win ? 32'h200 : 32'h100);
    set_m(win, 0, 0, 0, 0, 0);
    #2 chk("tie.dropping", grant, onehot(win + 1));
    tick; #2;
    chk("tie.handoff", grant, onehot(2 - win));
    chk("tie.handoff_addr", s.addr, win ? 32'h100 : 32'h200);
    set_m(1 - win, 0, 0, 0, 0, 0);
    tick; #2 chk("tie.idle", grant, 2'b00);
    // lock: m1 does three beats while m0 waits
    set_m(1, 1, 1, 1, 32'h20, 32'hA0);
    tick;
    set_m(0, 1, 1, 0, 32'h300, 0);
    for (int i = 0; i < 3; i++) begin
      s.ack = 1'b1;
      m1.addr = 32'h20 + 32'(4 * i);
      m1.wdata = 32'hA0 + 32'(i);
      #2;
      chk_outs($sformatf("lock.beat%0d", i), 2'b10, 1, 1, 0, 1, 0, 0);
      chk($sformatf("lock.addr%0d", i), s.addr, 32'h20 + 32'(4 * i));
      chk($sformatf("lock.wdata%0d", i), s.wdata, 32'hA0 + 32'(i));
      chk($sformatf("lock.we%0d", i), s.we, 1);
      tick;
    end
    s.ack = 1'b0;
    set_m(1, 0, 0, 0, 0, 0);
    #2 chk("lock.release", grant, 2'b10);
    tick; #2 chk("lock.handoff", grant, 2'b01);
    set_m(0, 0, 0, 0, 0, 0);
    tick; #2 chk("lock.idle", grant, 2'b00);
    // watchdog on an unanswered m1 write
    set_m(1, 1, 1, 1, 32'h40, 32'h77);
    tick;
    for (int i = 0; i < T; i++) begin
      #2 chk_outs($sformatf("wd.wait%0d", i), 2'b10, 1, 1, 0, 0, 0, 0);
      tick;
    end
    #2 chk_outs("wd.err", 2'b10, 1, 0, 0, 0, 0, 1);
    tick; #2 chk_outs("wd.after", 2'b10, 1, 1, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick; tick;
    // asynchronous reset in the middle of an m0 access
    set_m(0, 1, 1, 0, 32'h80, 0);
    tick; #2;
    chk_outs("rst.pre", 2'b01, 1, 1, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_outs("rst.async", 2'b00, 0, 0, 0, 0, 0, 0);
    chk("rst.s_addr", s.addr, 0);
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick; #2 chk("rst.m1_grant", grant, 2'b10);
    set_m(1, 0, 0, 0, 0, 0);
    tick; tick;
    // both masters doing one-beat cycles continuously
    reset = 1'b1;
    #1 reset = 1'b0;
    set_m(0, 1, 1, 0, 32'h500, 0);
    set_m(1, 1, 1, 0, 32'h600, 0);
    tick;
    exp_own = 0;
    for (int i = 0; i < 4; i++) begin
      s.ack = 1'b1;
      #2;
      chk_outs($sformatf("alt.beat%0d", i), onehot(exp_own + 1), 1, 1, exp_own == 0, exp_own == 1, 0, 0);
      tick;
      s.ack = 1'b0;
      set_m(exp_own, 0, 0, 0, 0, 0);
      #2 chk($sformatf("alt.hold%0d", i), grant, onehot(exp_own + 1));
      tick;
      set_m(exp_own, 1, 1, 0, exp_own ? 32'h600 : 32'h500, 0);
      exp_own = 1 - exp_own;
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick; tick;
    // random traffic against the model
    reset = 1'b1;
    #1 reset = 1'b0;
    own = 0; pend = 0; mlast = 1'b1; merr = 1'b0;
    pc0 = 0; ps0 = 0; pc1 = 0; ps1 = 0; pa = 0;
    for (int n = 0; n < 600; n++) begin
      tick;
      advance();
      m0.cyc = m0.cyc ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      m1.cyc = m1.cyc ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      m0.stb = m0.cyc && ($urandom_range(0, 3) != 0);
      m1.stb = m1.cyc && ($urandom_range(0, 3) != 0);
      m0.addr = $urandom; m1.addr = $urandom;
      m0.wdata = $urandom; m1.wdata = $urandom;
      m0.we = 1'($urandom); m1.we = 1'($urandom);
      m0.sel = 4'($urandom); m1.sel = 4'($urandom);
      s.rdata = $urandom;
      #1;
      s.ack = s.stb && ($urandom_range(0, 2) == 0);
      #1;
      eg = onehot(own);
      chk_outs("rnd", eg,
               own == 1 ? m0.cyc : own == 2 ? m1.cyc : 1'b0,
               (own == 1 ? m0.stb : own == 2 ? m1.stb : 1'b0) && !merr,
               own == 1 && s.ack, own == 2 && s.ack, own == 1 && merr, own == 2 && merr);
      chk("rnd.s_addr", s.addr, own == 1 ? m0.addr : own == 2 ? m1.addr : 32'h0);
      chk("rnd.s_wdata", s.wdata, own == 1 ? m0.wdata : own == 2 ? m1.wdata : 32'h0);
      chk("rnd.s_sel", s.sel, own == 1 ? m0.sel : own == 2 ? m1.sel : 4'h0);
      chk("rnd.s_we", s.we, own == 1 ? m0.we : own == 2 ? m1.we : 1'b0);
      chk("rnd.m0_rdata", m0.rdata, s.rdata);
      pc0 = m0.cyc; ps0 = m0.stb; pc1 = m1.cyc; ps1 = m1.stb; pa = s.ack;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
